// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM SD controller:
// FSM state encoding, backup image header words and sector geometry.
package bk_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FMT     = 3'd1,
    BK_REQ  = 3'd2,
    BK_XFER = 3'd3,
    CD_REQ  = 3'd4,
    CD_XFER = 3'd5
  } bk_state_e;

  localparam int SECTOR_WORDS = 32'd256;

  // Entry 0 is written first, at address 0
  localparam logic [3:0][15:0] BK_HDR = {16'h8010, 16'h8800, 16'h4D42, 16'h5548};

  function automatic logic [15:0] fmt_word(input logic [1:0] idx, input logic in_hdr);
    if (in_hdr) begin
      fmt_word = BK_HDR[idx];
    end else begin
      fmt_word = 16'h0000;
    end
  endfunction

endpackage

// File: rtl/bk_sd_ctrl_edge.sv
// Rising-edge detector feeding a sticky pending bit; a new edge wins over
// a same-cycle clear so a request arriving at acceptance is not lost.
module bk_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic lvl,
  input  logic pulse,
  input  logic clr,
  output logic pend
);

  logic prev_r;
  logic pend_r;
  logic set_s;

  assign set_s = (lvl & ~prev_r) | pulse;

  // level history and sticky request bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      prev_r <= lvl;
      if (!ena) begin
        pend_r <= 1'b0;
      end else if (set_s) begin
        pend_r <= 1'b1;
      end else if (clr) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  assign pend = pend_r;

endmodule

// File: rtl/bk_sd_ctrl.sv
// Backup-RAM save/load/format engine sharing the HPS SD channel with the
// CD-ROM reader; the CD may only interleave at sector boundaries.
module bk_sd_ctrl
  import bk_pkg::*;
#(
  parameter int SECTORS   = 32'd16,
  parameter int LBA_W     = 32'd32,
  parameter int FMT_CLEAR = 32'd0
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          bk_ena,
  input  logic                          bk_load,
  input  logic                          bk_save,
  input  logic                          format,
  input  logic                          bk_autoload,
  input  logic [LBA_W-1:0]              cd_lba,
  input  logic                          cd_rd,
  output logic                          cd_ack,
  output logic [LBA_W-1:0]              sd_lba,
  output logic                          sd_rd,
  output logic                          sd_wr,
  input  logic                          sd_ack,
  input  logic [7:0]                    sd_buff_addr,
  input  logic [15:0]                   sd_buff_dout,
  input  logic                          sd_buff_wr,
  output logic [$clog2(SECTORS)+7:0]    bram_addr,
  output logic [15:0]                   bram_din,
  output logic                          bram_we,
  output logic                          bk_loading,
  output logic                          bk_busy
);

  localparam int SEC_BITS = $clog2(SECTORS);
  localparam int SEC_W    = (SEC_BITS > 0) ? SEC_BITS : 32'd1;
  localparam int ADDR_W   = SEC_BITS + 32'd8;
  localparam logic [SEC_W-1:0]  LAST_SEC = SEC_W'(SECTORS - 32'sd1);
  localparam logic [SEC_W-1:0]  SEC_ONE  = SEC_W'(32'd1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'd1);
  localparam logic [ADDR_W-1:0] HDR_LEN  = ADDR_W'(32'd4);
  localparam logic [ADDR_W-1:0] FMT_LAST = (FMT_CLEAR != 32'sd0) ?
                                           ADDR_W'(SECTORS * SECTOR_WORDS - 32'sd1) :
                                           ADDR_W'(32'd3);

  bk_state_e         state_r, state_s;
  logic [SEC_W-1:0]  sector_r, sector_s;
  logic [ADDR_W-1:0] fmt_cnt_r, fmt_cnt_s;
  logic              loading_r, loading_s;
  logic              active_r, active_s;
  logic              busy_r, sd_rd_r, sd_wr_r, ack_r;
  logic              clr_fmt_s, clr_load_s, clr_save_s;
  logic              pend_fmt_s, pend_load_s, pend_save_s;
  logic              ack_rise_s, ack_fall_s, cd_state_s;
  logic [SEC_W+7:0]  xfer_addr_s;
  logic              bram_we_s;
  logic [ADDR_W-1:0] bram_addr_s;
  logic [15:0]       bram_din_s;

  bk_edge_latch u_fmt_latch (
    .clk(clk_sys), .rst(reset), .ena(1'b1), .lvl(format),
    .pulse(1'b0), .clr(clr_fmt_s), .pend(pend_fmt_s)
  );

  bk_edge_latch u_load_latch (
    .clk(clk_sys), .rst(reset), .ena(bk_ena), .lvl(bk_load),
    .pulse(bk_autoload), .clr(clr_load_s), .pend(pend_load_s)
  );

  bk_edge_latch u_save_latch (
    .clk(clk_sys), .rst(reset), .ena(bk_ena), .lvl(bk_save),
    .pulse(1'b0), .clr(clr_save_s), .pend(pend_save_s)
  );

  assign ack_rise_s = sd_ack & ~ack_r;
  assign ack_fall_s = ~sd_ack & ack_r;

  // next-state, sector and format-address logic
  always_comb begin
    state_s    = state_r;
    sector_s   = sector_r;
    fmt_cnt_s  = fmt_cnt_r;
    loading_s  = loading_r;
    active_s   = active_r;
    clr_fmt_s  = 1'b0;
    clr_load_s = 1'b0;
    clr_save_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cd_rd) begin
          state_s = CD_REQ;
        end else if (pend_fmt_s) begin
          state_s   = FMT;
          fmt_cnt_s = '0;
          clr_fmt_s = 1'b1;
        end else if (pend_load_s) begin
          state_s    = BK_REQ;
          sector_s   = '0;
          loading_s  = 1'b1;
          active_s   = 1'b1;
          clr_load_s = 1'b1;
        end else if (pend_save_s) begin
          state_s    = BK_REQ;
          sector_s   = '0;
          loading_s  = 1'b0;
          active_s   = 1'b1;
          clr_save_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FMT: begin
        if (fmt_cnt_r == FMT_LAST) begin
          state_s   = IDLE;
          fmt_cnt_s = '0;
        end else begin
          fmt_cnt_s = fmt_cnt_r + ADDR_ONE;
        end
      end
      BK_REQ: begin
        if (ack_rise_s) begin
          state_s = BK_XFER;
        end else begin
          state_s = BK_REQ;
        end
      end
      BK_XFER: begin
        if (ack_fall_s) begin
          if (sector_r == LAST_SEC) begin
            state_s   = IDLE;
            sector_s  = '0;
            loading_s = 1'b0;
            active_s  = 1'b0;
          end else if (cd_rd) begin
            state_s  = CD_REQ;
            sector_s = sector_r + SEC_ONE;
          end else begin
            state_s  = BK_REQ;
            sector_s = sector_r + SEC_ONE;
          end
        end else begin
          state_s = BK_XFER;
        end
      end
      CD_REQ: begin
        if (ack_rise_s) begin
          state_s = CD_XFER;
        end else begin
          state_s = CD_REQ;
        end
      end
      CD_XFER: begin
        if (ack_fall_s) begin
          state_s = active_r ? BK_REQ : IDLE;
        end else begin
          state_s = CD_XFER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state and registered SD request outputs, derived from the next state
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      sector_r  <= '0;
      fmt_cnt_r <= '0;
      loading_r <= 1'b0;
      active_r  <= 1'b0;
      busy_r    <= 1'b0;
      sd_rd_r   <= 1'b0;
      sd_wr_r   <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      sector_r  <= sector_s;
      fmt_cnt_r <= fmt_cnt_s;
      loading_r <= loading_s;
      active_r  <= active_s;
      busy_r    <= (state_s == FMT) | active_s;
      sd_rd_r   <= ((state_s == BK_REQ) & loading_s) | (state_s == CD_REQ);
      sd_wr_r   <= (state_s == BK_REQ) & ~loading_s;
      ack_r     <= sd_ack;
    end
  end

  assign cd_state_s  = (state_r == CD_REQ) | (state_r == CD_XFER);
  assign xfer_addr_s = {sector_r, sd_buff_addr};

  // backup-RAM port B: format pattern or pass-through of the HPS buffer
  always_comb begin
    bram_we_s   = 1'b0;
    bram_addr_s = '0;
    bram_din_s  = 16'h0000;
    if (state_r == FMT) begin
      bram_we_s   = 1'b1;
      bram_addr_s = fmt_cnt_r;
      bram_din_s  = fmt_word(fmt_cnt_r[1:0], fmt_cnt_r < HDR_LEN);
    end else if (state_r == BK_XFER) begin
      bram_addr_s = xfer_addr_s[ADDR_W-1:0];
      if (loading_r) begin
        bram_we_s  = sd_buff_wr & sd_ack;
        bram_din_s = sd_buff_dout;
      end else begin
        bram_we_s  = 1'b0;
        bram_din_s = 16'h0000;
      end
    end else begin
      bram_we_s = 1'b0;
    end
  end

  assign bram_we    = bram_we_s;
  assign bram_addr  = bram_addr_s;
  assign bram_din   = bram_din_s;
  assign sd_lba     = cd_state_s ? cd_lba : LBA_W'(sector_r);
  assign sd_rd      = sd_rd_r;
  assign sd_wr      = sd_wr_r;
  assign cd_ack     = cd_state_s & sd_ack;
  assign bk_loading = loading_r;
  assign bk_busy    = busy_r;

endmodule

// File: tb/tb_bk_sd_ctrl.sv
// Directed bench for bk_sd_ctrl: save, load with CD interleave, format
// (header-only and full clear), dual request, disabled image, reset mid-load.
module tb_bk_sd_ctrl;

  logic        clk = 1'b0;
  logic        reset, bk_ena, bk_load, bk_save, format, bk_autoload;
  logic [31:0] cd_lba;
  logic        cd_rd, sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;

  logic        cd_ack, sd_rd, sd_wr, bram_we, bk_loading, bk_busy;
  logic [31:0] sd_lba;
  logic [11:0] bram_addr;
  logic [15:0] bram_din;

  logic        c_cd_ack, c_sd_rd, c_sd_wr, c_bram_we, c_bk_loading, c_bk_busy;
  logic [31:0] c_sd_lba;
  logic [11:0] c_bram_addr;
  logic [15:0] c_bram_din;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int we2_cnt  = 0;
  int req_cnt  = 0;
  logic req_prev = 1'b0;
  logic [15:0] mem  [0:4095];
  logic [15:0] mem2 [0:4095];

  always #5 clk = ~clk;

  bk_sd_ctrl #(.SECTORS(16), .LBA_W(32), .FMT_CLEAR(0)) dut (
    .clk_sys(clk), .reset(reset), .bk_ena(bk_ena), .bk_load(bk_load),
    .bk_save(bk_save), .format(format), .bk_autoload(bk_autoload),
    .cd_lba(cd_lba), .cd_rd(cd_rd), .cd_ack(cd_ack), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_we(bram_we), .bk_loading(bk_loading), .bk_busy(bk_busy)
  );

  bk_sd_ctrl #(.SECTORS(16), .LBA_W(32), .FMT_CLEAR(1)) dut_clr (
    .clk_sys(clk), .reset(reset), .bk_ena(bk_ena), .bk_load(bk_load),
    .bk_save(bk_save), .format(format), .bk_autoload(bk_autoload),
    .cd_lba(cd_lba), .cd_rd(cd_rd), .cd_ack(c_cd_ack), .sd_lba(c_sd_lba),
    .sd_rd(c_sd_rd), .sd_wr(c_sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .bram_addr(c_bram_addr),
    .bram_din(c_bram_din), .bram_we(c_bram_we), .bk_loading(c_bk_loading), .bk_busy(c_bk_busy)
  );

  // backup-RAM models and traffic counters
  always @(posedge clk) begin
    if (bram_we === 1'b1) begin
      we_cnt <= we_cnt + 1;
      mem[bram_addr] <= bram_din;
    end
    if (c_bram_we === 1'b1) begin
      we2_cnt <= we2_cnt + 1;
      mem2[c_bram_addr] <= c_bram_din;
    end
    if ((sd_rd | sd_wr) && !req_prev) req_cnt <= req_cnt + 1;
    req_prev <= sd_rd | sd_wr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one HPS sector exchange for the backup owner; load data is {sector, word}
  // except sector 15 which carries 0xA5A5
  task automatic bk_sector(input logic exp_rd, input int sec, input logic cd_mid);
    int n;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("bk_req_timeout", 32'd0, 32'd1);
      return;
    end
    chk("bk_lba", sd_lba, 32'(sec));
    chk("bk_rd", sd_rd, exp_rd);
    chk("bk_wr", sd_wr, !exp_rd);
    chk("bk_busy", bk_busy, 1'b1);
    sd_ack = 1'b1;
    @(negedge clk);
    chk("req_drop", sd_rd | sd_wr, 1'b0);
    chk("cd_ack_gated", cd_ack, 1'b0);
    for (int i = 0; i < 256; i++) begin
      sd_buff_addr = 8'(i);
      sd_buff_dout = (sec == 15) ? 16'hA5A5 : {8'(sec), 8'(i)};
      sd_buff_wr   = exp_rd;
      if (cd_mid && i == 128) begin
        cd_lba = 32'h0000_1234;
        cd_rd  = 1'b1;
      end
      @(negedge clk);
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
  endtask

  task automatic cd_sector();
    int n;
    n = 0;
    while (!sd_rd && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("cd_req_timeout", 32'd0, 32'd1);
      return;
    end
    chk("cd_lba", sd_lba, 32'h0000_1234);
    chk("cd_no_wr", sd_wr, 1'b0);
    chk("cd_loading", bk_loading, 1'b1);
    sd_ack = 1'b1;
    @(negedge clk);
    chk("cd_ack_hi", cd_ack, 1'b1);
    chk("cd_rd_drop", sd_rd, 1'b0);
    cd_rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sd_buff_addr = 8'(i);
      sd_buff_dout = 16'hDEAD;
      sd_buff_wr   = 1'b1;
      @(negedge clk);
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    @(negedge clk);
    chk("cd_ack_lo", cd_ack, 1'b0);
  endtask

  initial begin
    int base, base2, n;
    reset = 1'b1; bk_ena = 1'b1; bk_load = 1'b0; bk_save = 1'b0; format = 1'b0;
    bk_autoload = 1'b0; cd_lba = 32'd0; cd_rd = 1'b0; sd_ack = 1'b0;
    sd_buff_wr = 1'b0; sd_buff_addr = 8'd0; sd_buff_dout = 16'd0;
    repeat (3) @(negedge clk);

    // reset state of both instances
    chk("rst_sd_rd", {sd_rd, sd_wr, cd_ack, bram_we, bk_loading, bk_busy}, 6'd0);
    chk("rst_sd_lba", sd_lba, 32'd0);
    chk("rst_bram", {bram_addr, bram_din}, 28'd0);
    chk("rst_clr_ctl", {c_sd_rd, c_sd_wr, c_cd_ack, c_bram_we, c_bk_loading, c_bk_busy}, 6'd0);
    chk("rst_clr_bus", {c_bram_addr, c_bram_din}, 28'd0);
    chk("rst_clr_lba", c_sd_lba, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // save: edge to sd_wr in two cycles, sixteen sectors, no RAM writes
    base = we_cnt;
    bk_save = 1'b1;
    @(negedge clk);
    chk("save_lat1", sd_wr, 1'b0);
    @(negedge clk);
    chk("save_lat2", sd_wr, 1'b1);
    bk_save = 1'b0;
    for (int s = 0; s < 16; s++) bk_sector(1'b0, s, 1'b0);
    repeat (2) @(negedge clk);
    chk("save_busy_end", bk_busy, 1'b0);
    chk("save_no_we", we_cnt - base, 32'd0);

    // load with a CD request during sector 3
    base = we_cnt;
    bk_load = 1'b1;
    for (int s = 0; s < 16; s++) begin
      bk_sector(1'b1, s, s == 3);
      if (s == 0) bk_load = 1'b0;
      if (s == 3) cd_sector();
    end
    chk("load_loading_last", bk_loading, 1'b1);
    @(negedge clk);
    chk("load_loading_end", bk_loading, 1'b0);
    chk("load_busy_end", bk_busy, 1'b0);
    chk("load_we_cnt", we_cnt - base, 32'd4096);
    chk("load_word_fff", mem[12'hFFF], 16'hA5A5);
    chk("load_word_37f", mem[12'h37F], 16'h037F);

    // format: header-only instance and full-clear instance
    base = we_cnt; base2 = we2_cnt;
    format = 1'b1;
    repeat (10) @(negedge clk);
    format = 1'b0;
    chk("fmt_we_cnt", we_cnt - base, 32'd4);
    chk("fmt_hdr0", mem[0], 16'h5548);
    chk("fmt_hdr1", mem[1], 16'h4D42);
    chk("fmt_hdr2", mem[2], 16'h8800);
    chk("fmt_hdr3", mem[3], 16'h8010);
    chk("fmt_keep4", mem[4], 16'h0004);
    chk("fmt_clr_busy", c_bk_busy, 1'b1);
    n = 0;
    while (c_bk_busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("fmt_clr_timeout", n < 5000, 1'b1);
    chk("fmt_clr_we_cnt", we2_cnt - base2, 32'd4096);
    chk("fmt_clr_hdr0", mem2[0], 16'h5548);
    chk("fmt_clr_word4", mem2[4], 16'h0000);
    chk("fmt_clr_wordfff", mem2[12'hFFF], 16'h0000);

    // load and save rising together: full load, then full save
    base = we_cnt;
    bk_load = 1'b1; bk_save = 1'b1;
    for (int s = 0; s < 16; s++) begin
      bk_sector(1'b1, s, 1'b0);
      if (s == 0) begin bk_load = 1'b0; bk_save = 1'b0; end
    end
    for (int s = 0; s < 16; s++) bk_sector(1'b0, s, 1'b0);
    repeat (2) @(negedge clk);
    chk("dual_we_cnt", we_cnt - base, 32'd4096);
    chk("dual_busy_end", bk_busy, 1'b0);

    // image not enabled: edges are ignored and not remembered
    base = req_cnt;
    bk_ena = 1'b0;
    @(negedge clk);
    bk_load = 1'b1; bk_save = 1'b1;
    repeat (20) @(negedge clk);
    chk("noena_req", req_cnt - base, 32'd0);
    bk_load = 1'b0; bk_save = 1'b0;
    @(negedge clk);
    bk_ena = 1'b1;
    repeat (5) @(negedge clk);
    chk("noena_after", req_cnt - base, 32'd0);

    // reset during sector 7 of a load, then autoload restarts at lba 0
    bk_load = 1'b1;
    for (int s = 0; s < 7; s++) begin
      bk_sector(1'b1, s, 1'b0);
      if (s == 0) bk_load = 1'b0;
    end
    n = 0;
    while (!sd_rd && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst7_lba", sd_lba, 32'd7);
    sd_ack = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sd_buff_addr = 8'(i); sd_buff_dout = 16'h7777; sd_buff_wr = 1'b1;
      @(negedge clk);
    end
    chk("rst7_we_before", bram_we, 1'b1);
    chk("rst7_loading_before", bk_loading, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst7_sd_rd", sd_rd, 1'b0);
    chk("rst7_loading", bk_loading, 1'b0);
    chk("rst7_we", bram_we, 1'b0);
    chk("rst7_busy", bk_busy, 1'b0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bk_autoload = 1'b1;
    @(negedge clk);
    bk_autoload = 1'b0;
    bk_sector(1'b1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
